ex_hazard_ctrl: RTL

Hazard and forwarding controller for the execute stage. It keeps a shadow scoreboard of the register, LR and FL writers in flight in EX and MEM. From that it generates the registered forwarding selects the execute stage consumes, plus the stall, bubble and flush controls for the front of the pipeline. It sits beside the decode/execute boundary and is clocked with the pipeline registers.

---
 rtl/ex_hazard_ctrl_if.sv | 52 +++++
 rtl/ex_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl_if.sv
// Decode/execute-side bundle for the hazard controller: decode fields, EX redirect, and the
// forwarding selects plus front-end stall/flush controls. Counters exist only with HAZ_PERF_CNT_EN.
interface ex_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic             de_valid;
    logic [REG_W-1:0] de_rs1;
    logic [REG_W-1:0] de_rs2;
    logic             de_rs1_used;
    logic             de_rs2_used;
    logic [REG_W-1:0] de_rd;
    logic             de_reg_wrt_en;
    logic             de_is_load;
    logic             de_uses_LR;
    logic             de_wrt_LR;
    logic             de_uses_FL;
    logic             de_wrt_FL;
    logic             ex_redirect;
    logic [1:0]       forward1_sel;
    logic [1:0]       forward2_sel;
    logic             forward_LR_sel;
    logic [1:0]       forward_FL_sel;
    logic             stall_fd;
    logic             bubble_de;
    logic             flush_fd;
    logic             flush_de;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport master (
        output de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd, de_reg_wrt_en,
        output de_is_load, de_uses_LR, de_wrt_LR, de_uses_FL, de_wrt_FL, ex_redirect,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        input  forward1_sel, forward2_sel, forward_LR_sel, forward_FL_sel,
        input  stall_fd, bubble_de, flush_fd, flush_de
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd, de_reg_wrt_en,
        input  de_is_load, de_uses_LR, de_wrt_LR, de_uses_FL, de_wrt_FL, ex_redirect,
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        output forward1_sel, forward2_sel, forward_LR_sel, forward_FL_sel,
        output stall_fd, bubble_de, flush_fd, flush_de
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard/forwarding controller with an EX/MEM shadow scoreboard.
// Optional saturating stall/flush counters are built when HAZ_PERF_CNT_EN is defined.
module ex_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    ex_hazard_ctrl_if.slave     hz
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_wrt_en;
        logic             is_load;
        logic             wrt_lr;
        logic             wrt_fl;
    } shadow_t;

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e     state_q, state_d;
    shadow_t    ex_q, ex_d, mem_q;
    logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d, fwd_fl_q, fwd_fl_d;
    logic       fwd_lr_q, fwd_lr_d;

    logic de_live, m1_ex, m1_mem, m2_ex, m2_mem, lr_in_flight, load_use, stall, flush;

    function automatic logic src_match(shadow_t s, logic [REG_W-1:0] src, logic used);
        return s.valid && s.reg_wrt_en && (s.rd == src) && (src != '0) && used;
    endfunction

    always_comb begin
        // Decode is ignored during the cycle after a redirect.
        de_live      = hz.de_valid && (state_q != StFlush);
        m1_ex        = de_live && src_match(ex_q, hz.de_rs1, hz.de_rs1_used);
        m1_mem       = de_live && src_match(mem_q, hz.de_rs1, hz.de_rs1_used);
        m2_ex        = de_live && src_match(ex_q, hz.de_rs2, hz.de_rs2_used);
        m2_mem       = de_live && src_match(mem_q, hz.de_rs2, hz.de_rs2_used);
        lr_in_flight = (ex_q.valid && ex_q.wrt_lr) || (mem_q.valid && mem_q.wrt_lr);
        load_use     = (state_q == StRun) && ex_q.valid && ex_q.is_load && (m1_ex || m2_ex);
        flush        = hz.ex_redirect;
        stall        = load_use && !flush;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (flush) state_d = StFlush; else if (stall) state_d = StStall;
            StStall: state_d = flush ? StFlush : StRun;
            StFlush: state_d = flush ? StFlush : StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        fwd1_d   = 2'd0;
        fwd2_d   = 2'd0;
        fwd_lr_d = 1'b0;
        fwd_fl_d = 2'd0;
        ex_d     = '0;
        // The EX slot gets a bubble on stall or flush; its selects stay 0.
        if (de_live && !stall && !flush) begin
            ex_d.valid      = 1'b1;
            ex_d.rd         = hz.de_rd;
            ex_d.reg_wrt_en = hz.de_reg_wrt_en;
            ex_d.is_load    = hz.de_is_load;
            ex_d.wrt_lr     = hz.de_wrt_LR;
            ex_d.wrt_fl     = hz.de_wrt_FL;

            if (hz.de_uses_LR) begin
                fwd1_d   = lr_in_flight ? 2'd3 : 2'd0;
                fwd_lr_d = !(ex_q.valid && ex_q.wrt_lr);
            end else if (m1_ex) begin
                fwd1_d = 2'd1;
            end else if (m1_mem) begin
                fwd1_d = 2'd2;
            end

            if (m2_ex) begin
                fwd2_d = 2'd1;
            end else if (m2_mem) begin
                fwd2_d = 2'd2;
            end

            if (hz.de_uses_FL) begin
                if (ex_q.valid && ex_q.wrt_fl) begin
                    fwd_fl_d = 2'd1;
                end else if (mem_q.valid && mem_q.wrt_fl) begin
                    fwd_fl_d = 2'd2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            ex_q     <= '0;
            mem_q    <= '0;
            fwd1_q   <= 2'd0;
            fwd2_q   <= 2'd0;
            fwd_lr_q <= 1'b0;
            fwd_fl_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            mem_q    <= ex_q;
            fwd1_q   <= fwd1_d;
            fwd2_q   <= fwd2_d;
            fwd_lr_q <= fwd_lr_d;
            fwd_fl_q <= fwd_fl_d;
        end
    end

    assign hz.forward1_sel   = fwd1_q;
    assign hz.forward2_sel   = fwd2_q;
    assign hz.forward_LR_sel = fwd_lr_q;
    assign hz.forward_FL_sel = fwd_fl_q;
    assign hz.stall_fd       = stall;
    assign hz.bubble_de      = stall;
    assign hz.flush_fd       = flush;
    assign hz.flush_de       = flush;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule
